// File: rtl/alu_acc_stage.sv
// Two-stage signed add / saturating-accumulate stage that sits after the multiply stage.
// Stage 1 registers the exact sum of both products. Stage 2 resolves the op against the accumulator.
module alu_acc_stage #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           op,
  input  logic [BUS_WIDTH-1:0] mult_a,
  input  logic [BUS_WIDTH-1:0] mult_b,
  input  logic                 ovf_clr,
  output logic [BUS_WIDTH-1:0] result,
  output logic                 result_valid,
  output logic [BUS_WIDTH-1:0] acc,
  output logic                 ovf
);

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ACC  = 2'b01,
    OP_CLR  = 2'b10,
    OP_READ = 2'b11
  } op_t;

  localparam int WW = BUS_WIDTH + 2;
  localparam logic signed [WW-1:0] SAT_MAX = {3'b000, {(BUS_WIDTH-1){1'b1}}};
  localparam logic signed [WW-1:0] SAT_MIN = {3'b111, {(BUS_WIDTH-1){1'b0}}};

  // Both ADD sums and ACC sums are widened to WW bits, so one clamp handles both cases.
  function automatic logic [BUS_WIDTH-1:0] sat(input logic signed [WW-1:0] x);
    if (x > SAT_MAX)      sat = SAT_MAX[BUS_WIDTH-1:0];
    else if (x < SAT_MIN) sat = SAT_MIN[BUS_WIDTH-1:0];
    else                  sat = x[BUS_WIDTH-1:0];
  endfunction

  function automatic logic clamps(input logic signed [WW-1:0] x);
    clamps = (x > SAT_MAX) || (x < SAT_MIN);
  endfunction

  logic                 s1_valid;
  logic [BUS_WIDTH:0]   s1_sum;
  op_t                  s1_op;
  logic [BUS_WIDTH:0]   sum_in;

  logic signed [WW-1:0] sum_wide;
  logic signed [WW-1:0] acc_wide;
  logic [BUS_WIDTH-1:0] result_nxt;
  logic [BUS_WIDTH-1:0] acc_nxt;
  logic                 sat_event;
  logic                 ovf_nxt;

  assign sum_in = {mult_a[BUS_WIDTH-1], mult_a} + {mult_b[BUS_WIDTH-1], mult_b};

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    result_nxt = result;
    acc_nxt    = acc;
    sat_event  = 1'b0;
    sum_wide   = {s1_sum[BUS_WIDTH], s1_sum};
    acc_wide   = {{2{acc[BUS_WIDTH-1]}}, acc} + {s1_sum[BUS_WIDTH], s1_sum};
    if (s1_valid) begin
      unique case (s1_op)
        OP_ADD: begin
          result_nxt = sat(sum_wide);
          sat_event  = clamps(sum_wide);
        end
        OP_ACC: begin
          acc_nxt    = sat(acc_wide);
          result_nxt = sat(acc_wide);
          sat_event  = clamps(acc_wide);
        end
        OP_CLR: begin
          acc_nxt    = '0;
          result_nxt = '0;
        end
        OP_READ: result_nxt = acc;
        default: ;
      endcase
    end
    // A saturation event on the same edge beats ovf_clr.
    ovf_nxt = sat_event | (ovf & ~ovf_clr);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    // NOTE: reset here is synchronous and also flushes both valid bits, which drops in-flight work.
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_sum       <= '0;
      s1_op        <= OP_ADD;
      result       <= '0;
      result_valid <= 1'b0;
      acc          <= '0;
      ovf          <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sum <= sum_in;
        s1_op  <= op_t'(op);
      end
      result_valid <= s1_valid;
      result       <= result_nxt;
      acc          <= acc_nxt;
      ovf          <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_alu_acc_stage.sv
// Self-checking bench for alu_acc_stage. It runs directed scenarios and then random traffic.
// An integer reference model follows the op semantics, with a one-transaction delay line standing in for the pipeline.
module tb_alu_acc_stage;

  localparam int W = 8;
  localparam logic [1:0] ADD = 2'b00, ACC = 2'b01, CLR = 2'b10, READ = 2'b11;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] mult_a = '0;
  logic [W-1:0] mult_b = '0;
  logic         ovf_clr = 1'b0;
  logic [W-1:0] result;
  logic         result_valid;
  logic [W-1:0] acc;
  logic         ovf;

  int total = 0;
  int bad = 0;

  // Reference model state.
  int m_acc = 0, m_res = 0, m_rv = 0, m_ovf = 0;
  int p_valid = 0, p_sum = 0;
  logic [1:0] p_op = 2'b00;

  alu_acc_stage #(.BUS_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .op(op),
    .mult_a(mult_a), .mult_b(mult_b), .ovf_clr(ovf_clr),
    .result(result), .result_valid(result_valid), .acc(acc), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int clamp(input int x);
    if (x > 127) return 127;
    if (x < -128) return -128;
    return x;
  endfunction

  // One edge of the reference model. The transaction presented now is seen at the next edge.
  task automatic model_edge(input bit iv, input logic [1:0] o, input int a, input int b,
                            input bit oc, input bit r);
    int s;
    bit ev;
    if (r) begin
      m_acc = 0; m_res = 0; m_rv = 0; m_ovf = 0; p_valid = 0;
      return;
    end
    ev = 1'b0;
    m_rv = p_valid;
    if (p_valid != 0) begin
      case (p_op)
        ADD:  begin s = clamp(p_sum); ev = (s != p_sum); m_res = s; end
        ACC:  begin s = clamp(m_acc + p_sum); ev = (s != m_acc + p_sum); m_acc = s; m_res = s; end
        CLR:  begin m_acc = 0; m_res = 0; end
        default: m_res = m_acc;
      endcase
    end
    if (ev) m_ovf = 1;
    else if (oc) m_ovf = 0;
    p_valid = iv;
    if (iv) begin p_op = o; p_sum = a + b; end
  endtask

  // Present one cycle of inputs, step the model at the edge, and compare every output 1 time unit later.
  task automatic go(input bit iv, input logic [1:0] o, input int a, input int b,
                    input bit oc = 1'b0, input bit r = 1'b0);
    @(negedge clk);
    in_valid = iv; op = o; mult_a = W'(a); mult_b = W'(b); ovf_clr = oc; rst = r;
    @(posedge clk);
    model_edge(iv, o, a, b, oc, r);
    #1;
    check("result_valid", int'(result_valid), m_rv);
    check("result", int'($signed(result)), m_res);
    check("acc", int'($signed(acc)), m_acc);
    check("ovf", int'(ovf), m_ovf);
  endtask

  task automatic idle(input bit oc = 1'b0);
    go(1'b0, ADD, 0, 0, oc, 1'b0);
  endtask

  initial begin
    go(0, ADD, 0, 0, 0, 1);
    go(0, ADD, 0, 0, 0, 1);
    check("reset_acc", int'($signed(acc)), 0);
    check("reset_rv", int'(result_valid), 0);

    // A plain ADD shows up two edges after it is presented.
    go(1, ADD, 50, 60);
    idle();
    check("add_50_60", int'($signed(result)), 110);
    check("add_50_60_rv", int'(result_valid), 1);
    idle();
    check("add_rv_one_cycle", int'(result_valid), 0);

    // Saturation at both rails, then a standalone ovf_clr.
    go(1, ADD, 100, 100);
    go(1, ADD, -100, -100);
    check("add_sat_hi", int'($signed(result)), 127);
    check("add_sat_hi_ovf", int'(ovf), 1);
    idle();
    check("add_sat_lo", int'($signed(result)), -128);
    idle(1'b1);
    check("ovf_clr_alone", int'(ovf), 0);

    // Back-to-back CLR, ACC, ACC, READ.
    go(1, CLR, 0, 0);
    go(1, ACC, 10, 5);
    check("b2b_clr", int'($signed(result)), 0);
    go(1, ACC, 20, -3);
    check("b2b_acc1", int'($signed(result)), 15);
    go(1, READ, 0, 0);
    check("b2b_acc2", int'($signed(result)), 32);
    idle();
    check("b2b_read", int'($signed(result)), 32);
    check("b2b_acc_final", int'($signed(acc)), 32);

    // Preload -120, saturate at -128, then recover to -1.
    go(1, CLR, 0, 0);
    go(1, ACC, -60, -60);
    go(1, ACC, -10, -5);
    go(1, ACC, 100, 27);
    check("acc_sat_lo", int'($signed(acc)), -128);
    check("acc_sat_lo_res", int'($signed(result)), -128);
    check("acc_sat_lo_ovf", int'(ovf), 1);
    idle();
    check("acc_recover", int'($signed(acc)), -1);
    check("acc_recover_ovf", int'(ovf), 1);

    // When ovf_clr lands on the same edge as a saturating ADD, the set wins.
    idle(1'b1);
    go(1, ADD, 127, 1);
    idle(1'b1);
    check("set_beats_clr", int'(ovf), 1);

    // A reset with an ACC in flight drops the ACC.
    go(1, ACC, 5, 5);
    go(0, ADD, 0, 0, 0, 1);
    idle();
    check("rst_drop_rv", int'(result_valid), 0);
    check("rst_drop_acc", int'($signed(acc)), 0);
    check("rst_drop_ovf", int'(ovf), 0);
    go(1, ADD, 1, 2);
    idle();
    check("post_rst_add", int'($signed(result)), 3);
    check("post_rst_add_rv", int'(result_valid), 1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int a, b;
      a = int'($signed(8'($urandom)));
      b = int'($signed(8'($urandom)));
      go(($urandom % 4) != 0, 2'($urandom), a, b,
         ($urandom % 8) == 0, ($urandom % 60) == 0);
    end
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
